// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: one radix-2 step per cycle, fixed latency.
// Optional macro MULDIV_SIGNED_EN enables signed MULT/DIV; otherwise op_i[0] is ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             divzero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               accept;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign divzero_o = divzero_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign accept    = (state_q == IDLE) && start_i && !flush_i;

  // Multiply: accumulate into the high half, shift the multiplier out of the low half.
  assign sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  // Divide: partial remainder lives in acc_hi, quotient bits shift into acc_lo.
  assign rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opb_q};
  assign prod   = {acc_hi_q, acc_lo_q};

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q, aneg_q;

  assign a_neg = op_i[0] & a_i[WIDTH-1];
  assign b_neg = op_i[0] & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // The most-negative / -1 case needs no special handling: negating 2^(WIDTH-1) wraps to itself.
  assign prod_fix = neg_q  ? -prod     : prod;
  assign q_fix    = neg_q  ? -acc_lo_q : acc_lo_q;
  assign r_fix    = aneg_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      neg_q  <= 1'b0;
      aneg_q <= 1'b0;
    end else if (accept) begin
      neg_q  <= a_neg ^ b_neg;
      aneg_q <= a_neg;
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = op_i[0];
  assign a_mag      = a_i;
  assign b_mag      = b_i;
  assign prod_fix   = prod;
  assign q_fix      = acc_lo_q;
  assign r_fix      = acc_hi_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    if (!busy_o && hi_we_i) hi_d = wdata_i;
    if (!busy_o && lo_we_i) lo_d = wdata_i;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = CALC;
            cnt_d    = '0;
            is_div_d = op_i[1];
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            opb_d    = b_mag;
          end
        end
        CALC: begin
          if (is_div_q) begin
            acc_hi_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            divzero_d = (opb_q == '0);
            lo_d      = (opb_q == '0) ? {WIDTH{1'b1}} : q_fix;
            hi_d      = r_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width (SHALL be an even value >= 4).
REQ-002 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request a new operation; accepted only in IDLE.
REQ-005 op_i  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a_i  input  WIDTH  multiplicand or dividend.
REQ-007 b_i  input  WIDTH  multiplier or divisor.
REQ-008 flush_i  input  1  abort any operation in progress.
REQ-009 hi_we_i  input  1  MTHI write enable.
REQ-010 lo_we_i  input  1  MTLO write enable.
REQ-011 wdata_i  input  WIDTH  MTHI/MTLO write data.
REQ-012 busy_o  output  1  high while state is not IDLE.
REQ-013 done_o  output  1  one-cycle pulse: HI/LO hold a new result.
REQ-014 divzero_o  output  1  one-cycle pulse with done_o when the divisor was zero.
REQ-015 hi_o  output  WIDTH  HI register (upper product half or remainder).
REQ-016 lo_o  output  WIDTH  LO register (lower product half or quotient).

Function
REQ-017 States SHALL be IDLE, CALC and FIX; every transition occurs on a clock edge.
REQ-018 IDLE with start_i=1 and flush_i=0: capture op_i, a_i and b_i, clear the iteration counter, go to CALC.
REQ-019 CALC: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, for exactly WIDTH cycles, then go to FIX.
REQ-020 FIX: apply sign correction, write HI/LO, assert done_o for the following cycle, go to IDLE.
REQ-021 Latency: done_o SHALL be high in the cycle after the (WIDTH+2)th edge counted from the accepting edge (34th for WIDTH=32); latency is identical for all ops and operand values.
REQ-022 A start_i pulse in the done_o cycle SHALL be accepted; start_i while busy_o=1 SHALL be ignored.
REQ-023 Multiply result: {hi_o,lo_o} = full 2*WIDTH-bit product.
REQ-024 Signed multiply: the product of the magnitudes is negated when the operand signs differ.
REQ-025 Divide result: lo_o = quotient, hi_o = remainder.
REQ-026 Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-027 Divide by zero: lo_o = all ones, hi_o = dividend; divzero_o pulses with done_o; latency unchanged.
REQ-028 Signed overflow (most-negative value / -1): lo_o = most-negative value, hi_o = 0, no flag.
REQ-029 flush_i=1 SHALL return the unit to IDLE on the next edge with HI/LO unchanged and no done_o pulse.
REQ-030 flush_i has priority over start_i in the same cycle.
REQ-031 hi_we_i/lo_we_i SHALL write wdata_i into HI/LO only when busy_o=0; they are ignored while busy.
REQ-032 A write and an accepted start in the same IDLE cycle both take effect; the later result overwrites HI/LO.

Reset
REQ-033 rst_i low SHALL immediately force state IDLE, busy_o=0, done_o=0, divzero_o=0, hi_o=0, lo_o=0 and counter=0, including in the middle of an operation.
REQ-034 After rst_i deasserts, the first start_i SHALL be accepted on the next edge.

Configuration
REQ-035 Macro MULDIV_SIGNED_EN: when defined, MULT and DIV SHALL apply the signed rules in REQ-024, REQ-026 and REQ-028.
REQ-036 When MULDIV_SIGNED_EN is undefined, op_i[0] SHALL be ignored, MULT/DIV SHALL behave exactly as MULTU/DIVU, and the sign-correction logic SHALL be absent; the FIX state and the latency remain.

Verification (WIDTH=32)
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done_o in the 34th cycle after acceptance, busy_o low in that cycle.
REQ-038 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without the macro -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-039 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, divzero_o=1 with done_o.
REQ-041 MULTU started, flush_i at CALC cycle 10 -> busy_o=0 next cycle, no done_o, HI/LO keep prior values. start_i during CALC is ignored.
REQ-042 rst_i low at CALC cycle 5 -> all outputs 0 immediately. MTHI 0x1234 while busy is ignored. MTHI 0x1234 in IDLE -> hi_o=0x1234 next cycle.
